// File: rtl/rf_arb_pkg.sv
// Shared widths, source encoding and entry type for the register-file writeback arbiter.
package rf_arb_pkg;

  localparam int XLEN  = 64;
  localparam int REG_AW = 5;
  localparam int CNT_W = 16;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  // Round-robin pointer: which requester wins the next conflict.
  typedef enum logic {
    PTR_A = 1'b0,
    PTR_B = 1'b1
  } rr_ptr_e;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Requester handshakes plus register-file write port of the writeback arbiter.
interface rf_wb_arbiter_if;
  import rf_arb_pkg::*;

  logic              a_valid;
  logic              a_ready;
  logic [REG_AW-1:0] a_rd;
  logic [XLEN-1:0]   a_data;

  logic              b_valid;
  logic              b_ready;
  logic [REG_AW-1:0] b_rd;
  logic [XLEN-1:0]   b_data;

  logic              rf_we;
  logic [REG_AW-1:0] rf_rd;
  logic [XLEN-1:0]   rf_wdata;
  logic              rf_src_b;
  logic [CNT_W-1:0]  conflict_cnt;

  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    input  a_ready, b_ready, rf_we, rf_rd, rf_wdata, rf_src_b, conflict_cnt
  );

  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    output a_ready, b_ready, rf_we, rf_rd, rf_wdata, rf_src_b, conflict_cnt
  );

endinterface

// File: rtl/rf_wb_slot.sv
// One-entry writeback buffer; accepts a new entry while being drained so a stream has no bubbles.
module rf_wb_slot
  import rf_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  output logic              ready,
  input  logic [REG_AW-1:0] rd,
  input  logic [XLEN-1:0]   data,
  input  logic              drain,
  output logic              full,
  output wb_entry_t         entry
);

  assign ready = ~reset & (~full | drain);

  always_ff @(posedge clk) begin
    if (reset)
      full <= 1'b0;
    else if (valid && ready)
      full <= 1'b1;
    else if (drain)
      full <= 1'b0;
  end

  // Payload carries no reset; the full flag alone qualifies it.
  always_ff @(posedge clk) begin
    if (valid && ready) begin
      entry.rd   <= rd;
      entry.data <= data;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Two-requester register-file writeback arbiter (A = ALU, B = load).
// Define RF_WB_ARB_RR_EN for round-robin conflict resolution; otherwise A has fixed priority.
module rf_wb_arbiter
  import rf_arb_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  rf_wb_arbiter_if.slave  bus
);

  logic      a_vld_p0, b_vld_p0;
  wb_entry_t a_ent_p0, b_ent_p0;
  logic      a_gnt, b_gnt, any_gnt, both_full;
  wb_entry_t sel_ent;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Stage p0: per-requester one-entry slots
  rf_wb_slot u_slot_a (
    .clk   (clk),
    .reset (reset),
    .valid (bus.a_valid),
    .ready (bus.a_ready),
    .rd    (bus.a_rd),
    .data  (bus.a_data),
    .drain (a_gnt),
    .full  (a_vld_p0),
    .entry (a_ent_p0)
  );

  rf_wb_slot u_slot_b (
    .clk   (clk),
    .reset (reset),
    .valid (bus.b_valid),
    .ready (bus.b_ready),
    .rd    (bus.b_rd),
    .data  (bus.b_data),
    .drain (b_gnt),
    .full  (b_vld_p0),
    .entry (b_ent_p0)
  );

  assign both_full = a_vld_p0 & b_vld_p0;
  assign any_gnt   = a_gnt | b_gnt;

`ifdef RF_WB_ARB_RR_EN
  rr_ptr_e ptr_q, ptr_d;

  always_ff @(posedge clk) begin
    if (reset)
      ptr_q <= PTR_A;
    else
      ptr_q <= ptr_d;
  end

  // The requester granted last yields the next conflict.
  always_comb begin
    a_gnt = a_vld_p0 & (~b_vld_p0 | (ptr_q == PTR_A));
    b_gnt = b_vld_p0 & ~a_gnt;
    ptr_d = ptr_q;
    if (a_gnt)
      ptr_d = PTR_B;
    else if (b_gnt)
      ptr_d = PTR_A;
  end
`else
  always_comb begin
    a_gnt = a_vld_p0;
    b_gnt = b_vld_p0 & ~a_vld_p0;
  end
`endif

  always_comb begin
    sel_ent = a_ent_p0;
    if (b_gnt)
      sel_ent = b_ent_p0;
  end

  // Stage p1: registered register-file write port; rd==0 drains without writing
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rf_we    <= 1'b0;
      bus.rf_rd    <= '0;
      bus.rf_wdata <= '0;
      bus.rf_src_b <= SRC_A;
    end else begin
      bus.rf_we <= any_gnt && (sel_ent.rd != '0);
      if (any_gnt) begin
        bus.rf_rd    <= sel_ent.rd;
        bus.rf_wdata <= sel_ent.data;
        bus.rf_src_b <= b_gnt ? SRC_B : SRC_A;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      bus.conflict_cnt <= '0;
    else if (both_full)
      bus.conflict_cnt <= sat_inc(bus.conflict_cnt);
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter; follows RF_WB_ARB_RR_EN to pick the arbitration model.
module tb_rf_wb_arbiter;
  import rf_arb_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  rf_wb_arbiter_if ifc ();

  rf_wb_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  // Reference model: two pending-write buffers, a record of who was granted last,
  // and the last value presented to the register file.
  bit                m_full [2];
  logic [REG_AW-1:0] m_rd   [2];
  logic [XLEN-1:0]   m_dat  [2];
  bit                m_next_b;
  bit                m_rdy  [2];
  int                m_gnt;
  bit                m_we;
  logic [REG_AW-1:0] m_ord;
  logic [XLEN-1:0]   m_owd;
  bit                m_src;
  logic [CNT_W-1:0]  m_cnt;

  task automatic m_decide();
    m_gnt = -1;
    if (m_full[0] && m_full[1]) begin
`ifdef RF_WB_ARB_RR_EN
      m_gnt = m_next_b ? 1 : 0;
`else
      m_gnt = 0;
`endif
    end else if (m_full[0]) m_gnt = 0;
    else if (m_full[1]) m_gnt = 1;
    m_rdy[0] = !reset && (!m_full[0] || m_gnt == 0);
    m_rdy[1] = !reset && (!m_full[1] || m_gnt == 1);
  endtask

  task automatic drive(input bit av, input int ard, input logic [XLEN-1:0] adat,
                       input bit bv, input int brd, input logic [XLEN-1:0] bdat);
    ifc.a_valid = av; ifc.a_rd = REG_AW'(ard); ifc.a_data = adat;
    ifc.b_valid = bv; ifc.b_rd = REG_AW'(brd); ifc.b_data = bdat;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, '0, 0, 0, '0);
  endtask

  // Advance one clock edge and apply the behavioural rules to the model.
  task automatic tick();
    bit hs_a, hs_b, rst_s;
    logic [REG_AW-1:0] ard, brd;
    logic [XLEN-1:0] adat, bdat;
    m_decide();
    hs_a = ifc.a_valid && m_rdy[0];
    hs_b = ifc.b_valid && m_rdy[1];
    ard = ifc.a_rd; adat = ifc.a_data; brd = ifc.b_rd; bdat = ifc.b_data;
    rst_s = reset;
    @(posedge clk);
    if (rst_s) begin
      m_full[0] = 0; m_full[1] = 0; m_next_b = 0;
      m_we = 0; m_ord = '0; m_owd = '0; m_src = 0; m_cnt = '0;
    end else begin
      if (m_full[0] && m_full[1] && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
      m_we = 0;
      if (m_gnt >= 0) begin
        m_we = (m_rd[m_gnt] != 0);
        m_ord = m_rd[m_gnt];
        m_owd = m_dat[m_gnt];
        m_src = (m_gnt == 1);
        m_next_b = (m_gnt == 0);
        m_full[m_gnt] = 0;
      end
      if (hs_a) begin m_full[0] = 1; m_rd[0] = ard; m_dat[0] = adat; end
      if (hs_b) begin m_full[1] = 1; m_rd[1] = brd; m_dat[1] = bdat; end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; idle(); tick(); reset = 1'b0; #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle();
    n_chk++; if (ifc.a_ready !== 1'b0) begin n_fail++; $display("FAIL rst_a_ready got %b exp 0", ifc.a_ready); end
    n_chk++; if (ifc.b_ready !== 1'b0) begin n_fail++; $display("FAIL rst_b_ready got %b exp 0", ifc.b_ready); end
    tick(); tick();
    n_chk++; if (ifc.rf_we !== 1'b0) begin n_fail++; $display("FAIL rst_we got %b exp 0", ifc.rf_we); end
    n_chk++; if (ifc.rf_rd !== 5'd0) begin n_fail++; $display("FAIL rst_rd got %0d exp 0", ifc.rf_rd); end
    n_chk++; if (ifc.rf_wdata !== 64'd0) begin n_fail++; $display("FAIL rst_wdata got %h exp 0", ifc.rf_wdata); end
    n_chk++; if (ifc.rf_src_b !== 1'b0) begin n_fail++; $display("FAIL rst_src got %b exp 0", ifc.rf_src_b); end
    n_chk++; if (ifc.conflict_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_cnt got %0d exp 0", ifc.conflict_cnt); end
    reset = 1'b0; #1;
    n_chk++; if (ifc.a_ready !== 1'b1) begin n_fail++; $display("FAIL rst_rel_a_ready got %b exp 1", ifc.a_ready); end
  endtask

  task automatic test_a_only();
    drive(1, 5, 64'h1234, 0, 0, '0);
    n_chk++; if (ifc.a_ready !== 1'b1) begin n_fail++; $display("FAIL aonly_ready got %b exp 1", ifc.a_ready); end
    tick(); idle();
    n_chk++; if (ifc.rf_we !== 1'b0) begin n_fail++; $display("FAIL aonly_early_we got %b exp 0", ifc.rf_we); end
    tick();
    n_chk++; if (ifc.rf_we !== 1'b1) begin n_fail++; $display("FAIL aonly_we got %b exp 1", ifc.rf_we); end
    n_chk++; if (ifc.rf_rd !== 5'd5) begin n_fail++; $display("FAIL aonly_rd got %0d exp 5", ifc.rf_rd); end
    n_chk++; if (ifc.rf_wdata !== 64'h1234) begin n_fail++; $display("FAIL aonly_wdata got %h exp 1234", ifc.rf_wdata); end
    n_chk++; if (ifc.rf_src_b !== 1'b0) begin n_fail++; $display("FAIL aonly_src got %b exp 0", ifc.rf_src_b); end
    tick();
    n_chk++; if (ifc.rf_we !== 1'b0) begin n_fail++; $display("FAIL aonly_we_drop got %b exp 0", ifc.rf_we); end
    n_chk++; if (ifc.rf_rd !== 5'd5 || ifc.rf_wdata !== 64'h1234) begin n_fail++; $display("FAIL aonly_hold got rd=%0d data=%h exp rd=5 data=1234", ifc.rf_rd, ifc.rf_wdata); end
  endtask

  task automatic test_conflict();
    do_reset();
    drive(1, 3, 64'hAA, 1, 4, 64'hBB);
    n_chk++; if (ifc.a_ready !== 1'b1 || ifc.b_ready !== 1'b1) begin n_fail++; $display("FAIL conf_ready got a=%b b=%b exp 1 1", ifc.a_ready, ifc.b_ready); end
    tick(); idle(); tick();
    n_chk++; if (ifc.rf_we !== 1'b1 || ifc.rf_rd !== 5'd3 || ifc.rf_wdata !== 64'hAA || ifc.rf_src_b !== 1'b0) begin n_fail++; $display("FAIL conf_first got we=%b rd=%0d data=%h src=%b exp 1 3 aa 0", ifc.rf_we, ifc.rf_rd, ifc.rf_wdata, ifc.rf_src_b); end
    n_chk++; if (ifc.conflict_cnt !== 16'd1) begin n_fail++; $display("FAIL conf_cnt1 got %0d exp 1", ifc.conflict_cnt); end
    tick();
    n_chk++; if (ifc.rf_we !== 1'b1 || ifc.rf_rd !== 5'd4 || ifc.rf_wdata !== 64'hBB || ifc.rf_src_b !== 1'b1) begin n_fail++; $display("FAIL conf_second got we=%b rd=%0d data=%h src=%b exp 1 4 bb 1", ifc.rf_we, ifc.rf_rd, ifc.rf_wdata, ifc.rf_src_b); end
    n_chk++; if (ifc.conflict_cnt !== 16'd1) begin n_fail++; $display("FAIL conf_cnt1_hold got %0d exp 1", ifc.conflict_cnt); end
`ifdef RF_WB_ARB_RR_EN
    // A is granted alone, then both collide: B has not been granted last so B wins.
    drive(1, 7, 64'h77, 0, 0, '0); tick();
    drive(1, 3, 64'hAA, 1, 4, 64'hBB);
    n_chk++; if (ifc.a_ready !== 1'b1) begin n_fail++; $display("FAIL rr_refill_ready got %b exp 1", ifc.a_ready); end
    tick(); idle();
    n_chk++; if (ifc.rf_rd !== 5'd7 || ifc.rf_src_b !== 1'b0) begin n_fail++; $display("FAIL rr_solo got rd=%0d src=%b exp 7 0", ifc.rf_rd, ifc.rf_src_b); end
    tick();
    n_chk++; if (ifc.rf_we !== 1'b1 || ifc.rf_rd !== 5'd4 || ifc.rf_src_b !== 1'b1) begin n_fail++; $display("FAIL rr_repeat_b_first got we=%b rd=%0d src=%b exp 1 4 1", ifc.rf_we, ifc.rf_rd, ifc.rf_src_b); end
    n_chk++; if (ifc.conflict_cnt !== 16'd2) begin n_fail++; $display("FAIL rr_cnt2 got %0d exp 2", ifc.conflict_cnt); end
    tick();
    n_chk++; if (ifc.rf_we !== 1'b1 || ifc.rf_rd !== 5'd3 || ifc.rf_src_b !== 1'b0) begin n_fail++; $display("FAIL rr_repeat_a_second got we=%b rd=%0d src=%b exp 1 3 0", ifc.rf_we, ifc.rf_rd, ifc.rf_src_b); end
`else
    // A streams every cycle while B holds one entry and offers another.
    drive(1, 1, 64'h101, 1, 4, 64'hBB); tick();
    for (int i = 2; i <= 6; i++) begin
      drive(1, i, 64'h100 + 64'(i), 1, 6, 64'hCC);
      n_chk++; if (ifc.b_ready !== 1'b0 || ifc.a_ready !== 1'b1) begin n_fail++; $display("FAIL starve_ready i=%0d got a=%b b=%b exp 1 0", i, ifc.a_ready, ifc.b_ready); end
      tick();
      n_chk++; if (ifc.rf_src_b !== 1'b0 || ifc.rf_rd !== 5'(i - 1) || ifc.rf_wdata !== 64'h100 + 64'(i - 1)) begin n_fail++; $display("FAIL starve_write i=%0d got rd=%0d data=%h src=%b exp rd=%0d src=0", i, ifc.rf_rd, ifc.rf_wdata, ifc.rf_src_b, i - 1); end
    end
    drive(0, 0, '0, 1, 6, 64'hCC);
    n_chk++; if (ifc.b_ready !== 1'b0) begin n_fail++; $display("FAIL starve_last_bready got %b exp 0", ifc.b_ready); end
    tick();
    n_chk++; if (ifc.rf_rd !== 5'd6 || ifc.rf_src_b !== 1'b0) begin n_fail++; $display("FAIL starve_last_a got rd=%0d src=%b exp 6 0", ifc.rf_rd, ifc.rf_src_b); end
    n_chk++; if (ifc.conflict_cnt !== 16'd7) begin n_fail++; $display("FAIL starve_cnt got %0d exp 7", ifc.conflict_cnt); end
    n_chk++; if (ifc.b_ready !== 1'b1) begin n_fail++; $display("FAIL starve_release_bready got %b exp 1", ifc.b_ready); end
    tick(); idle();
    n_chk++; if (ifc.rf_we !== 1'b1 || ifc.rf_rd !== 5'd4 || ifc.rf_wdata !== 64'hBB || ifc.rf_src_b !== 1'b1) begin n_fail++; $display("FAIL starve_b1 got we=%b rd=%0d data=%h src=%b exp 1 4 bb 1", ifc.rf_we, ifc.rf_rd, ifc.rf_wdata, ifc.rf_src_b); end
    tick();
    n_chk++; if (ifc.rf_we !== 1'b1 || ifc.rf_rd !== 5'd6 || ifc.rf_wdata !== 64'hCC || ifc.rf_src_b !== 1'b1) begin n_fail++; $display("FAIL starve_b2 got we=%b rd=%0d data=%h src=%b exp 1 6 cc 1", ifc.rf_we, ifc.rf_rd, ifc.rf_wdata, ifc.rf_src_b); end
`endif
    tick();
  endtask

  task automatic test_rd_zero();
    drive(0, 0, '0, 1, 0, 64'hFF);
    n_chk++; if (ifc.b_ready !== 1'b1) begin n_fail++; $display("FAIL rd0_bready got %b exp 1", ifc.b_ready); end
    tick(); idle(); tick();
    n_chk++; if (ifc.rf_we !== 1'b0) begin n_fail++; $display("FAIL rd0_we got %b exp 0", ifc.rf_we); end
    n_chk++; if (ifc.rf_rd !== 5'd0 || ifc.rf_wdata !== 64'hFF || ifc.rf_src_b !== 1'b1) begin n_fail++; $display("FAIL rd0_bus got rd=%0d data=%h src=%b exp 0 ff 1", ifc.rf_rd, ifc.rf_wdata, ifc.rf_src_b); end
    drive(0, 0, '0, 1, 9, 64'h99);
    n_chk++; if (ifc.b_ready !== 1'b1) begin n_fail++; $display("FAIL rd0_next_bready got %b exp 1", ifc.b_ready); end
    tick(); idle(); tick();
    n_chk++; if (ifc.rf_we !== 1'b1 || ifc.rf_rd !== 5'd9 || ifc.rf_wdata !== 64'h99) begin n_fail++; $display("FAIL rd0_next got we=%b rd=%0d data=%h exp 1 9 99", ifc.rf_we, ifc.rf_rd, ifc.rf_wdata); end
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1, 10, 64'hA0, 1, 11, 64'hB0); tick(); idle();
    reset = 1'b1; #1;
    n_chk++; if (ifc.a_ready !== 1'b0 || ifc.b_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready got a=%b b=%b exp 0 0", ifc.a_ready, ifc.b_ready); end
    n_chk++; if (ifc.rf_we !== 1'b0) begin n_fail++; $display("FAIL midrst_we_pre got %b exp 0", ifc.rf_we); end
    tick();
    n_chk++; if (ifc.rf_we !== 1'b0 || ifc.rf_rd !== 5'd0 || ifc.rf_wdata !== 64'd0 || ifc.rf_src_b !== 1'b0 || ifc.conflict_cnt !== 16'd0) begin n_fail++; $display("FAIL midrst_outputs got we=%b rd=%0d data=%h src=%b cnt=%0d exp all 0", ifc.rf_we, ifc.rf_rd, ifc.rf_wdata, ifc.rf_src_b, ifc.conflict_cnt); end
    reset = 1'b0; #1;
    n_chk++; if (ifc.a_ready !== 1'b1 || ifc.b_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_release_ready got a=%b b=%b exp 1 1", ifc.a_ready, ifc.b_ready); end
    for (int k = 0; k < 2; k++) begin
      tick();
      n_chk++; if (ifc.rf_we !== 1'b0) begin n_fail++; $display("FAIL midrst_no_write k=%0d got %b exp 0", k, ifc.rf_we); end
    end
  endtask

  task automatic test_cnt_sat();
    int budget;
    do_reset();
    drive(1, 1, 64'h11, 1, 2, 64'h22);
    tick();
    budget = 70000;
    while (m_cnt != 16'hFFFE && budget > 0) begin tick(); budget--; end
    n_chk++; if (ifc.conflict_cnt !== 16'hFFFE) begin n_fail++; $display("FAIL sat_preload got %h exp fffe", ifc.conflict_cnt); end
    tick();
    n_chk++; if (ifc.conflict_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach got %h exp ffff", ifc.conflict_cnt); end
    repeat (3) tick();
    n_chk++; if (ifc.conflict_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got %h exp ffff", ifc.conflict_cnt); end
    idle(); repeat (3) tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      reset = ($urandom_range(0, 49) == 0);
      drive($urandom_range(0, 9) < 6, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 31), {$urandom, $urandom},
            $urandom_range(0, 9) < 6, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 31), {$urandom, $urandom});
      m_decide();
      n_chk++; if (ifc.a_ready !== m_rdy[0] || ifc.b_ready !== m_rdy[1]) begin n_fail++; $display("FAIL rnd_ready c=%0d got a=%b b=%b exp %b %b", c, ifc.a_ready, ifc.b_ready, m_rdy[0], m_rdy[1]); end
      tick();
      n_chk++; if (ifc.rf_we !== m_we || ifc.rf_rd !== m_ord || ifc.rf_wdata !== m_owd || ifc.rf_src_b !== m_src) begin n_fail++; $display("FAIL rnd_write c=%0d got we=%b rd=%0d data=%h src=%b exp we=%b rd=%0d data=%h src=%b", c, ifc.rf_we, ifc.rf_rd, ifc.rf_wdata, ifc.rf_src_b, m_we, m_ord, m_owd, m_src); end
      n_chk++; if (ifc.conflict_cnt !== m_cnt) begin n_fail++; $display("FAIL rnd_cnt c=%0d got %0d exp %0d", c, ifc.conflict_cnt, m_cnt); end
    end
    reset = 1'b0; idle(); repeat (3) tick();
  endtask

  initial begin
    idle();
    test_reset();
    test_a_only();
    test_conflict();
    test_rd_zero();
    test_reset_mid();
    test_cnt_sat();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 a_valid  in  1  requester A (ALU writeback) offers a write.
REQ-005 a_ready  out  1  requester A write accepted when a_valid && a_ready at the clock edge.
REQ-006 a_rd  in  5  requester A destination register index.
REQ-007 a_data  in  64  requester A write data.
REQ-008 b_valid, b_ready, b_rd, b_data  in/out/in/in  1/1/5/64  requester B (load writeback); same meaning as the A ports.
REQ-009 rf_we  out  1  register-file write enable (RegWrite).
REQ-010 rf_rd  out  5  register-file destination index (RD).
REQ-011 rf_wdata  out  64  register-file write data (WriteData).
REQ-012 rf_src_b  out  1  source of the current rf_* write: 0 = A, 1 = B.
REQ-013 conflict_cnt  out  16  count of cycles in which both slots were full.

Function
REQ-014 Each requester SHALL own a one-entry slot; x_ready = slot empty OR slot drained this cycle, forced 0 while reset is high.
REQ-015 On handshake the slot SHALL capture rd and data and become full at that edge.
REQ-016 Each cycle the arbiter SHALL select at most one full slot; the selected slot SHALL be drained at the next edge.
REQ-017 The drained entry SHALL be registered onto rf_rd, rf_wdata and rf_src_b at the same edge, with rf_we high for exactly one cycle per drained entry.
REQ-018 Latency SHALL be: handshake at edge E0, rf_we high in the cycle after edge E1 when uncontested; throughput SHALL be one write per cycle.
REQ-019 A drained entry with rd == 0 SHALL consume its arbitration slot but SHALL leave rf_we = 0; rf_rd/rf_wdata still update.
REQ-020 When no slot is selected, rf_we SHALL be 0 and rf_rd, rf_wdata, rf_src_b SHALL hold their values.
REQ-021 A slot drained and refilled in the same cycle SHALL hold the new entry with no bubble.
REQ-022 conflict_cnt SHALL increment on every cycle both slots are full and saturate at 16'hFFFF.
REQ-023 Same-rd writes from A and B SHALL reach the register file in grant order; no merging or dropping.

Reset
REQ-024 While reset is high at an edge: both slots empty, rf_we = 0, rf_rd = 0, rf_wdata = 0, rf_src_b = 0, conflict_cnt = 0, round-robin pointer = "A next".
REQ-025 Reset asserted mid-operation SHALL discard buffered entries with no register-file write in or after the reset cycle.

Configuration
REQ-026 Macro RF_WB_ARB_RR_EN defined: round-robin; when both slots are full, the slot not granted last wins; pointer updates on every grant.
REQ-027 Macro RF_WB_ARB_RR_EN undefined: fixed priority; A always wins a conflict; pointer logic absent.

Structure
REQ-028 Package rf_arb_pkg SHALL hold XLEN = 64, REG_AW = 5, CNT_W = 16 and the source encoding (SRC_A = 0, SRC_B = 1).
REQ-029 The one-entry slot SHALL be sub-module rf_wb_slot, instantiated once per requester.

Verification
REQ-030 The bench SHALL cover: A only, rd = 5, data = 64'h1234 -> rf_we high one cycle after E1 with rf_rd = 5, rf_wdata = 64'h1234, rf_src_b = 0.
REQ-031 The bench SHALL cover: A (rd 3, 64'hAA) and B (rd 4, 64'hBB) handshake on the same edge with RR enabled -> A written first, then B next cycle; conflict_cnt = 1; a repeat conflict grants B first.
REQ-032 The bench SHALL cover: same stimulus as REQ-031 with RR disabled and A streaming every cycle -> B starved and b_ready = 0 while A streams; conflict_cnt counts every such cycle.
REQ-033 The bench SHALL cover: B write with rd = 0, data = 64'hFF -> b_ready handshake completes, rf_we stays 0, next B write proceeds normally.
REQ-034 The bench SHALL cover: both slots full, reset pulsed one cycle -> no rf_we pulse, all outputs 0, a_ready/b_ready = 1 the cycle after reset deasserts.
REQ-035 The bench SHALL cover: conflict_cnt preloaded to 16'hFFFE via forced conflicts -> reads 16'hFFFF and holds on further conflicts.
